range_counter: RTL and testbench

RANGE_COUNTER -- requirements
Module: range_counter

---
 rtl/range_counter_pkg.sv | 18 +
 rtl/range_counter_step.sv | 60 ++++++
 rtl/range_counter.sv | 74 +++++++
 tb/tb_range_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/range_counter_pkg.sv
// Shared types and constants for the range counter: controller states and
// the encodings of the mode and direction inputs.
package range_counter_pkg;

  // One-hot state encoding so busy/done come straight off a single flop bit.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_ONESHOT    = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/range_counter_step.sv
// Next-count datapath: wrap/clamp arithmetic against the effective modulus,
// terminal-event detection, and clamping of load values into range.
module range_counter_step
  import range_counter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] range,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  output logic [WIDTH-1:0] next_count,
  output logic [WIDTH-1:0] load_clamped,
  output logic             terminal
);

  localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   FULL_MOD = {1'b1, {WIDTH{1'b0}}};

  // Effective modulus and its last value, kept one bit wider so range=0
  // means 2^WIDTH without overflowing.
  logic [WIDTH:0] modulus;
  logic [WIDTH:0] max_ext;
  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;

  assign modulus   = (range == '0) ? FULL_MOD : {1'b0, range};
  assign max_ext   = modulus - ONE_EXT;
  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_value};

  // Load values beyond the last legal count are pinned to the last count.
  assign load_clamped = (load_ext > max_ext) ? max_ext[WIDTH-1:0] : load_value;

  // Step in the requested direction; counts left above the range by a
  // range change wrap going up and clamp (silently) going down.
  always_comb begin
    next_count = count;
    terminal   = 1'b0;
    if (dir == DIR_UP) begin
      if (count_ext >= max_ext) begin
        next_count = '0;
        terminal   = 1'b1;
      end else begin
        next_count = count + ONE;
      end
    end else begin
      if (count == '0) begin
        next_count = max_ext[WIDTH-1:0];
        terminal   = 1'b1;
      end else if (count_ext > max_ext) begin
        next_count = max_ext[WIDTH-1:0];
      end else begin
        next_count = count - ONE;
      end
    end
  end

endmodule

// File: rtl/range_counter.sv
// Programmable-modulus up/down counter with IDLE/RUN/DONE control,
// continuous or one-shot operation and a registered terminal-count pulse.
module range_counter
  import range_counter_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] range,
  input  logic             mode,
  input  logic             dir,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             terminal;

  range_counter_step #(.WIDTH(WIDTH)) u_step (
    .count        (count),
    .range        (range),
    .load_value   (load_value),
    .dir          (dir),
    .next_count   (next_count),
    .load_clamped (load_clamped),
    .terminal     (terminal)
  );

  // Controller and counter registers; priority is clear, load, stop, start,
  // then stepping, and tc is raised for one cycle after a terminal step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= INIT;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clear) begin
        state <= IDLE;
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (stop) begin
        state <= IDLE;
      end else if (start) begin
        state <= RUN;
      end else if (state == RUN && en) begin
        count <= next_count;
        if (terminal) begin
          tc <= 1'b1;
          if (mode == MODE_ONESHOT) begin
            state <= DONE;
          end
        end
      end
    end
  end

  assign busy = state[1];
  assign done = state[2];

endmodule

// File: tb/tb_range_counter.sv
// Self-checking bench for range_counter: a table of single-cycle vectors
// fed through an expectation queue, plus a mid-count asynchronous reset.
module tb_range_counter;

  localparam int          WIDTH = 16;
  localparam logic [15:0] INIT  = 16'h0003;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] range = 16'd5;
  logic        mode = 1'b0;
  logic        dir = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count;
  logic        tc;
  logic        busy;
  logic        done;

  range_counter #(.WIDTH(WIDTH), .INIT(INIT)) dut (
    .clock      (clock),
    .reset      (reset),
    .range      (range),
    .mode       (mode),
    .dir        (dir),
    .en         (en),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        clr, ld, stp, sta, en, md, dr;
    logic [15:0] rng, lv;
    logic [15:0] exp_count;
    logic        exp_tc, exp_busy, exp_done;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] count;
    logic        tc, busy, done;
  } exp_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   check_count = 0;
  int   pass_count  = 0;

  task automatic add_vec(input string name, input logic clr, input logic ld,
                         input logic stp, input logic sta, input logic e,
                         input logic md, input logic dr, input logic [15:0] rng,
                         input logic [15:0] lv, input logic [15:0] ec,
                         input logic etc, input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.clr = clr; v.ld = ld; v.stp = stp; v.sta = sta;
    v.en = e; v.md = md; v.dr = dr; v.rng = rng; v.lv = lv;
    v.exp_count = ec; v.exp_tc = etc; v.exp_busy = eb; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  task automatic check_now(input string name, input logic [15:0] ec,
                           input logic etc, input logic eb, input logic ed);
    check_count++;
    if (count === ec && tc === etc && busy === eb && done === ed) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got count=%h tc=%b busy=%b done=%b, expected count=%h tc=%b busy=%b done=%b",
               name, count, tc, busy, done, ec, etc, eb, ed);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, then pop
  // and compare just after the rising edge that consumes it.
  task automatic apply_vec(input vec_t v);
    exp_t e;
    @(negedge clock);
    clear = v.clr; load = v.ld; stop = v.stp; start = v.sta; en = v.en;
    mode = v.md; dir = v.dr; range = v.rng; load_value = v.lv;
    e.name = v.name; e.count = v.exp_count; e.tc = v.exp_tc;
    e.busy = v.exp_busy; e.done = v.exp_done;
    scoreboard.push_back(e);
    @(posedge clock);
    #1;
    if (scoreboard.size() == 0) begin
      check_count++;
      $display("[TB] FAIL %s: scoreboard empty, got count=%h, expected an entry", v.name, count);
    end else begin
      e = scoreboard.pop_front();
      check_now(e.name, e.count, e.tc, e.busy, e.done);
    end
  endtask

  task automatic step_vec(input string name, input logic e, input logic md,
                          input logic dr, input logic [15:0] rng,
                          input logic [15:0] ec, input logic etc,
                          input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.clr = 0; v.ld = 0; v.stp = 0; v.sta = 0; v.en = e;
    v.md = md; v.dr = dr; v.rng = rng; v.lv = '0;
    v.exp_count = ec; v.exp_tc = etc; v.exp_busy = eb; v.exp_done = ed;
    apply_vec(v);
  endtask

  initial begin
    // name, clr, ld, stp, sta, en, md, dr, rng, lv, exp count, tc, busy, done
    add_vec("clear",        1,0,0,0,0, 0,1, 16'd5, 16'd0,    16'd0,    0,0,0);
    add_vec("idle_hold",    0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd0,    0,0,0);
    add_vec("start",        0,0,0,1,1, 0,1, 16'd5, 16'd0,    16'd0,    0,1,0);
    add_vec("up_1",         0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd1,    0,1,0);
    add_vec("up_2",         0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd2,    0,1,0);
    add_vec("up_3",         0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd3,    0,1,0);
    add_vec("up_4",         0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd4,    0,1,0);
    add_vec("up_wrap",      0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd0,    1,1,0);
    add_vec("up_after",     0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd1,    0,1,0);
    add_vec("en_low",       0,0,0,0,0, 0,1, 16'd5, 16'd0,    16'd1,    0,1,0);
    add_vec("up_again",     0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd2,    0,1,0);
    add_vec("stop",         0,0,1,0,1, 0,1, 16'd5, 16'd0,    16'd2,    0,0,0);
    add_vec("restart",      0,0,0,1,1, 0,1, 16'd5, 16'd0,    16'd2,    0,1,0);
    add_vec("load_clamp",   0,1,0,0,1, 0,1, 16'd5, 16'd9,    16'd4,    0,1,0);
    add_vec("wrap_loaded",  0,0,0,0,1, 0,1, 16'd5, 16'd0,    16'd0,    1,1,0);
    add_vec("load_fffe",    0,1,0,0,1, 0,1, 16'd0, 16'hFFFE, 16'hFFFE, 0,1,0);
    add_vec("full_ffff",    0,0,0,0,1, 0,1, 16'd0, 16'd0,    16'hFFFF, 0,1,0);
    add_vec("full_wrap",    0,0,0,0,1, 0,1, 16'd0, 16'd0,    16'h0000, 1,1,0);
    add_vec("full_after",   0,0,0,0,1, 0,1, 16'd0, 16'd0,    16'h0001, 0,1,0);
    add_vec("load_9",       0,1,0,0,1, 0,1, 16'd16, 16'd9,   16'd9,    0,1,0);
    add_vec("shrink_up",    0,0,0,0,1, 0,1, 16'd4, 16'd0,    16'd0,    1,1,0);
    add_vec("load_9b",      0,1,0,0,1, 0,0, 16'd16, 16'd9,   16'd9,    0,1,0);
    add_vec("shrink_down",  0,0,0,0,1, 0,0, 16'd4, 16'd0,    16'd3,    0,1,0);
    add_vec("down_2",       0,0,0,0,1, 0,0, 16'd4, 16'd0,    16'd2,    0,1,0);
    add_vec("clr_ld_start", 1,1,0,1,1, 0,0, 16'd4, 16'd5,    16'd0,    0,0,0);
    add_vec("load_idle",    0,1,0,0,0, 1,0, 16'd3, 16'd2,    16'd2,    0,0,0);
    add_vec("start_one",    0,0,0,1,1, 1,0, 16'd3, 16'd0,    16'd2,    0,1,0);
    add_vec("os_down_1",    0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd1,    0,1,0);
    add_vec("os_down_0",    0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd0,    0,1,0);
    add_vec("os_term",      0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd2,    1,0,1);
    add_vec("done_hold",    0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd2,    0,0,1);
    add_vec("done_start",   0,0,0,1,1, 1,0, 16'd3, 16'd0,    16'd2,    0,1,0);
    add_vec("os2_down_1",   0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd1,    0,1,0);
    add_vec("os2_down_0",   0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd0,    0,1,0);
    add_vec("os2_term",     0,0,0,0,1, 1,0, 16'd3, 16'd0,    16'd2,    1,0,1);
    add_vec("done_stop",    0,0,1,0,1, 1,0, 16'd3, 16'd0,    16'd2,    0,0,0);

    // Power-on reset, checked while still asserted.
    #3 reset = 1'b0;
    #4;
    check_now("reset_state", INIT, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i]);
    end

    // Reset pulsed mid-count: reach count 7 running, then drop reset
    // between edges and look before the next rising edge.
    begin
      vec_t v;
      v.name = "load_7"; v.clr = 0; v.ld = 1; v.stp = 0; v.sta = 0; v.en = 0;
      v.md = 0; v.dr = 1; v.rng = 16'd0; v.lv = 16'd6;
      v.exp_count = 16'd6; v.exp_tc = 0; v.exp_busy = 0; v.exp_done = 0;
      apply_vec(v);
      v.name = "start_7"; v.ld = 0; v.sta = 1; v.exp_busy = 1;
      apply_vec(v);
    end
    step_vec("run_7", 1, 0, 1, 16'd0, 16'd7, 0, 1, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_now("async_reset", INIT, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step_vec("post_reset_1", 1, 0, 1, 16'd0, INIT, 0, 0, 0);
    step_vec("post_reset_2", 1, 0, 1, 16'd0, INIT, 0, 0, 0);
    begin
      vec_t v;
      v.name = "post_start"; v.clr = 0; v.ld = 0; v.stp = 0; v.sta = 1; v.en = 1;
      v.md = 0; v.dr = 1; v.rng = 16'd0; v.lv = 16'd0;
      v.exp_count = INIT; v.exp_tc = 0; v.exp_busy = 1; v.exp_done = 0;
      apply_vec(v);
    end
    step_vec("post_step", 1, 0, 1, 16'd0, INIT + 16'd1, 0, 1, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
